booth_r4_multiply_unit: RTL and testbench

Parametrised iterative radix-4 Booth multiplier: the next-generation multiply functional unit of the MicroGT-01 execute stage. It supports all four RV32M multiply operations (MUL, MULH, MULHSU, MULHU) at any even XLEN. Operand signedness is handled in the datapath, with no post-correction. It uses valid/ready handshakes on both sides, a kill input for pipeline flush, and an optional operand-reuse shortcut for MULH/MUL pairs.

---
 rtl/booth_r4_multiply_unit_if.sv | 30 +++
 rtl/booth_r4_multiply_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_booth_r4_multiply_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_r4_multiply_unit_if.sv
// booth_r4_multiply_unit_if
//   Request/response bundle of the radix-4 Booth multiply unit.
//   Request : valid_i, ready_o, op_i, a_i, b_i
//   Response: valid_o, ready_i, result_o
//   Status  : busy_o
//   master modport: the issuing/consuming pipeline side.
//   slave  modport: the multiply unit.
interface booth_r4_multiply_unit_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [1:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output valid_i, op_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, result_o, busy_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, ready_i,
        output ready_o, valid_o, result_o, busy_o
    );
endinterface

// File: rtl/booth_r4_multiply_unit.sv
// booth_r4_multiply_unit
//   Iterative radix-4 Booth multiplier covering MUL, MULH, MULHSU and MULHU
//   for any even XLEN >= 4. Operands are extended to XLEN+2 bits according
//   to the operation's signedness, so the Booth recoding yields the exact
//   product without any post-correction. One operation takes ITER=(XLEN+2)/2
//   iterations; the result is then held until the consumer takes it.
//
//   Ports
//     clk_i     clock, all state on the rising edge
//     rst_i     synchronous reset, active-high (overrides everything)
//     clk_en_i  clock enable; low freezes all state and handshakes
//     kill_i    flush; aborts whatever is in flight
//     bus       booth_r4_multiply_unit_if.slave
//               (valid_i/ready_o/op_i/a_i/b_i, valid_o/ready_i/result_o, busy_o)
//
//   Build option
//     MUL_OPERAND_REUSE_EN: keeps the last completed operand pair and full
//     product; a matching request skips RUN and presents the result one
//     cycle after accept. Results are identical with or without it.
module booth_r4_multiply_unit #(
    parameter int XLEN = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    input  logic                    kill_i,
    booth_r4_multiply_unit_if.slave bus
);
    localparam int ITER = (XLEN + 2) / 2;
    localparam int EW   = XLEN + 2;       // extended operand width
    localparam int PW   = XLEN + 3;       // partial-product (P) width
    localparam int AW   = PW + EW + 1;    // {P, A, L}
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST   = CW'(ITER - 1);
    localparam logic [1:0]    OP_MUL = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              valid_q;
    logic              busy_q;
    logic [XLEN-1:0]   result_q;

    logic [EW-1:0]     mcand;
    logic [AW-1:0]     acc;
    logic              op_mul;

    // Signedness of each operand for the requested operation.
    logic              sgn_a;
    logic              sgn_b;
    logic [EW-1:0]     ext_a;
    logic [EW-1:0]     ext_b;
    logic              ready;
    logic              accept;
    logic              run_last;

    logic [PW-1:0]     m1;
    logic [PW-1:0]     m2;
    logic [PW-1:0]     booth_add;
    logic [PW-1:0]     p_sum;
    logic [AW-1:0]     acc_sum;
    logic [AW-1:0]     acc_next;
    logic [2*XLEN-1:0] prod_next;
    logic [XLEN-1:0]   run_result;

    logic              reuse_hit;
    logic [2*XLEN-1:0] reuse_prod;
    logic [XLEN-1:0]   hit_result;

    assign sgn_a = (bus.op_i != 2'b11);
    assign sgn_b = ~bus.op_i[1];
    assign ext_a = {{2{sgn_a & bus.a_i[XLEN-1]}}, bus.a_i};
    assign ext_b = {{2{sgn_b & bus.b_i[XLEN-1]}}, bus.b_i};

    assign ready    = (state == ST_IDLE) & ~kill_i & ~rst_i;
    assign accept   = bus.valid_i & ready & clk_en_i;
    assign run_last = (state == ST_RUN) & (cnt == LAST);

    // Multiplicand and its double, sign-extended to the P width.
    assign m1 = {mcand[EW-1], mcand};
    assign m2 = {mcand, 1'b0};

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        booth_add = '0;
        case (acc[2:0])
            3'b001, 3'b010: booth_add = m1;
            3'b011:         booth_add = m2;
            3'b100:         booth_add = -m2;
            3'b101, 3'b110: booth_add = -m1;
            default:        booth_add = '0;
        endcase
    end

    // Add into P, then arithmetic shift of the whole {P, A, L} by two.
    assign p_sum     = acc[AW-1 -: PW] + booth_add;
    assign acc_sum   = {p_sum, acc[EW:0]};
    assign acc_next  = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
    assign prod_next = acc_next[2*XLEN:1];

    assign run_result = op_mul ? prod_next[XLEN-1:0] : prod_next[2*XLEN-1:XLEN];
    assign hit_result = (bus.op_i == OP_MUL) ? reuse_prod[XLEN-1:0]
                                             : reuse_prod[2*XLEN-1:XLEN];

`ifdef MUL_OPERAND_REUSE_EN
    logic              reuse_vld;
    logic [XLEN-1:0]   reuse_a;
    logic [XLEN-1:0]   reuse_b;
    logic [1:0]        reuse_sgn;
    logic [2*XLEN-1:0] reuse_prod_q;
    logic [XLEN-1:0]   cur_a;
    logic [XLEN-1:0]   cur_b;
    logic [1:0]        cur_sgn;

    // The low half of a product does not depend on signedness, so MUL may
    // reuse any entry with matching operands.
    assign reuse_hit  = reuse_vld & (bus.a_i == reuse_a) & (bus.b_i == reuse_b) &
                        ((bus.op_i == OP_MUL) | ({sgn_a, sgn_b} == reuse_sgn));
    assign reuse_prod = reuse_prod_q;
`else
    assign reuse_hit  = 1'b0;
    assign reuse_prod = '0;
`endif

    // NOTE: operand, accumulator and reuse-payload registers carry no reset;
    // they are always loaded before being consumed, and only the control
    // state (including the reuse valid bit) needs a defined reset value.
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            if (accept) begin
                mcand  <= ext_a;
                acc    <= {{PW{1'b0}}, ext_b, 1'b0};
                op_mul <= (bus.op_i == OP_MUL);
`ifdef MUL_OPERAND_REUSE_EN
                cur_a   <= bus.a_i;
                cur_b   <= bus.b_i;
                cur_sgn <= {sgn_a, sgn_b};
`endif
            end else if (state == ST_RUN) begin
                acc <= acc_next;
            end
`ifdef MUL_OPERAND_REUSE_EN
            if (run_last & ~kill_i) begin
                reuse_a      <= cur_a;
                reuse_b      <= cur_b;
                reuse_sgn    <= cur_sgn;
                reuse_prod_q <= prod_next;
            end
`endif
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
`ifdef MUL_OPERAND_REUSE_EN
            reuse_vld <= 1'b0;
`endif
        end else if (clk_en_i) begin
            if (kill_i) begin
                // A kill also retires a pending result as delivered.
                state    <= ST_IDLE;
                cnt      <= '0;
                valid_q  <= 1'b0;
                busy_q   <= 1'b0;
                result_q <= '0;
`ifdef MUL_OPERAND_REUSE_EN
                if (state == ST_RUN) begin
                    reuse_vld <= 1'b0;
                end
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            if (reuse_hit) begin
                                state    <= ST_DONE;
                                valid_q  <= 1'b1;
                                result_q <= hit_result;
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        cnt <= cnt + CW'(1);
                        if (run_last) begin
                            state    <= ST_DONE;
                            valid_q  <= 1'b1;
                            result_q <= run_result;
`ifdef MUL_OPERAND_REUSE_EN
                            reuse_vld <= 1'b1;
`endif
                        end
                    end
                    ST_DONE: begin
                        if (bus.ready_i) begin
                            state    <= ST_IDLE;
                            valid_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            result_q <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ready_o  = ready;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign bus.busy_o   = busy_q;
endmodule

// File: tb/tb_booth_r4_multiply_unit.sv
// tb_booth_r4_multiply_unit
//   Scoreboard bench for booth_r4_multiply_unit at XLEN=32. Each accepted
//   request pushes its expected result and latency; a monitor compares
//   whenever the unit presents and delivers a result.
module tb_booth_r4_multiply_unit;
    localparam int XLEN = 32;
`ifdef MUL_OPERAND_REUSE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 17;
`endif

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;     // -1: latency not checked
        int              acc_cyc;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic clk_en_i;
    logic kill_i;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rand_phase = 0;
    exp_t sb_q[$];

    booth_r4_multiply_unit_if #(.XLEN(XLEN)) bus ();

    booth_r4_multiply_unit #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clk_en_i (clk_en_i),
        .kill_i   (kill_i),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: exact wide product of the operands interpreted per op.
    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [2*XLEN+1:0] sa, sb, p;
        sa = (op != 2'b11) ? {{(XLEN+2){a[XLEN-1]}}, a} : {{(XLEN+2){1'b0}}, a};
        sb = (op[1] == 1'b0) ? {{(XLEN+2){b[XLEN-1]}}, b} : {{(XLEN+2){1'b0}}, b};
        p  = sa * sb;
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, wait (bounded) for acceptance, record expectation.
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input int lat);
        int n = 0;
        @(negedge clk_i);
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.valid_i = 1'b1;
        while (!(bus.ready_o && clk_en_i)) begin
            @(negedge clk_i);
            n++;
            if (n > 500) begin
                fail_bound("accept");
                bus.valid_i = 1'b0;
                return;
            end
        end
        sb_q.push_back('{ref_mul(op, a, b), lat, cyc + 1});
        @(posedge clk_i);
        #1 bus.valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(sb_q.size() == 0 && bus.ready_o) && n < 2000);
        if (n >= 2000) fail_bound("drain");
    endtask

    // Monitor: latency on the rising valid_o, value on delivery.
    initial begin
        exp_t e;
        bit   prev_valid = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (bus.valid_o && !prev_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid result=0x%0h (t=%0t)", bus.result_o, $time);
                    end else if (sb_q[0].lat >= 0) begin
                        check("latency", 64'(cyc - sb_q[0].acc_cyc), 64'(sb_q[0].lat));
                    end
                end
                if (bus.valid_o && clk_en_i && sb_q.size() > 0) begin
                    if (kill_i) begin
                        void'(sb_q.pop_front());
                    end else if (bus.ready_i) begin
                        e = sb_q.pop_front();
                        check("result", 64'(bus.result_o), 64'(e.res));
                    end
                end
            end
            prev_valid = bus.valid_o;
        end
    end

    // Random backpressure and clock-enable gaps, changed away from sampling.
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (rand_phase) begin
                bus.ready_i = ($urandom_range(0, 3) != 0);
                clk_en_i    = ($urandom_range(0, 7) != 0);
            end
        end
    end

    initial begin
        logic [XLEN-1:0] exp_r;
        int n;
        rst_i       = 1'b1;
        clk_en_i    = 1'b1;
        kill_i      = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.a_i     = '0;
        bus.b_i     = '0;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_ready", 64'(bus.ready_o), 64'd0);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_result", 64'(bus.result_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_ready", 64'(bus.ready_o), 64'd1);

        // Signedness corners.
        issue(2'b00, 32'd7, 32'hFFFF_FFFD, 17);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 17);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17);
        wait_idle();

        // Result held under backpressure; no accept while DONE.
        bus.ready_i = 1'b0;
        exp_r = ref_mul(2'b01, 32'h0001_2345, 32'h6789_ABCD);
        issue(2'b01, 32'h0001_2345, 32'h6789_ABCD, 17);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!bus.valid_o && n < 100);
        if (n >= 100) fail_bound("done_wait");
        bus.op_i    = 2'b00;
        bus.a_i     = 32'd9;
        bus.b_i     = 32'd9;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(bus.valid_o), 64'd1);
            check("hold_result", 64'(bus.result_o), 64'(exp_r));
            check("hold_ready", 64'(bus.ready_o), 64'd0);
            check("hold_busy", 64'(bus.busy_o), 64'd1);
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1 bus.ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("post_hs_ready", 64'(bus.ready_o), 64'd1);
        check("post_hs_valid", 64'(bus.valid_o), 64'd0);
        check("post_hs_result", 64'(bus.result_o), 64'd0);
        check("post_hs_busy", 64'(bus.busy_o), 64'd0);
        bus.valid_i = 1'b0;

        // clk_en_i low for 3 cycles mid-RUN stretches latency to 20.
        issue(2'b10, 32'hDEAD_BEEF, 32'hCAFE_F00D, 20);
        repeat (5) @(posedge clk_i);
        #2 clk_en_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 clk_en_i = 1'b1;
        wait_idle();

        // Operand reuse: MUL after MULH hits, MULHU (other signedness) does not.
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 17);
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, HIT_LAT);
        issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 17);
        wait_idle();

        // Kill at iteration 8; also invalidates any reuse entry.
        issue(2'b00, 32'd3, 32'd5, 17);
        repeat (8) @(negedge clk_i);
        check("kill_busy_before", 64'(bus.busy_o), 64'd1);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1 kill_i = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk_i);
        check("kill_ready", 64'(bus.ready_o), 64'd1);
        check("kill_busy", 64'(bus.busy_o), 64'd0);
        check("kill_valid", 64'(bus.valid_o), 64'd0);
        // Kill in IDLE blocks a simultaneous request.
        kill_i      = 1'b1;
        bus.valid_i = 1'b1;
        #1 check("kill_idle_ready", 64'(bus.ready_o), 64'd0);
        @(posedge clk_i);
        #1 kill_i = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk_i);
        check("kill_idle_busy", 64'(bus.busy_o), 64'd0);
        issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 17);
        issue(2'b00, 32'd3, 32'd4, 17);
        wait_idle();

        // Randomized traffic with backpressure and enable gaps.
        rand_phase = 1;
        for (int i = 0; i < 60; i++) begin
            issue(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), -1);
        end
        rand_phase = 0;
        @(posedge clk_i);
        #3;
        bus.ready_i = 1'b1;
        clk_en_i    = 1'b1;
        wait_idle();
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
